// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: opcode constants, instruction field positions and
// the fetch-stage state encoding.
package fetch_unit_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BLT  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RS_MSB  = 11;
  localparam int unsigned RS_LSB  = 8;
  localparam int unsigned RT_MSB  = 7;
  localparam int unsigned RT_LSB  = 4;
  localparam int unsigned RD_MSB  = 3;
  localparam int unsigned RD_LSB  = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_FULL,
    S_HALTED,
    S_DRAIN
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request, one-entry
// instruction register toward decode, branch redirect and HALT handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = OP_HALT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  ipc_q, ipc_d;
  logic         halted_q, halted_d;
  logic         fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      ipc_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    halted_d = halted_q;
    imem_req = 1'b0;
    if_valid = (state_q == S_FULL) || ((state_q == S_HALTED) && !halted_q);
    fire     = if_valid && if_ready;

    unique case (state_q)
      S_IDLE: state_d = S_ISSUE;
      S_ISSUE: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          pc_d    = pc_q + 16'd1;
          state_d = (opcode_of(imem_rdata) == HALT_OP) ? S_HALTED : S_FULL;
        end
      end
      S_FULL: begin
        // Next request starts in the consuming cycle so a 1-cycle memory
        // sustains one instruction every two cycles.
        if (fire) begin
          imem_req = !redirect;
          state_d  = S_ISSUE;
        end
      end
      S_HALTED: begin
        if (fire) halted_d = 1'b1;
      end
      S_DRAIN: begin
        if (imem_valid) state_d = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides everything; a response still owed by memory must be
    // absorbed in DRAIN before the new address is requested.
    if (redirect) begin
      pc_d     = redirect_pc;
      instr_d  = instr_q;
      ipc_d    = ipc_q;
      halted_d = 1'b0;
      unique case (state_q)
        S_ISSUE, S_DRAIN: state_d = imem_valid ? S_ISSUE : S_DRAIN;
        S_FULL, S_HALTED: state_d = S_ISSUE;
        default:          state_d = S_ISSUE;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign if_instr  = instr_q;
  assign if_pc     = ipc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: program-order scoreboard model, a
// variable-latency memory responder and directed scenarios.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_valid;
  logic [15:0] imem_addr, imem_rdata;
  logic        if_valid, if_ready;
  logic [15:0] if_instr, if_pc;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;

  logic        req2, valid2, halted2;
  logic [15:0] addr2, instr2, pc2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned fire_cnt = 0;
  int unsigned mem_lat  = 1;

  logic [15:0] mem_img [logic [15:0]];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted)
  );

  // Same stimulus, different reset PC: its addresses trail dut by one.
  fetch_unit #(.RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req(req2), .imem_addr(addr2),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .if_valid(valid2), .if_ready(if_ready),
    .if_instr(instr2), .if_pc(pc2),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted2)
  );

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {4'h1, a[11:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int unsigned n = 0;
    @(negedge clk);
    while (!if_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, if_valid}, 32'd1);
  endtask

  // Memory: one request at a time, response mem_lat cycles after first req cycle.
  initial begin
    bit          busy = 0;
    int unsigned cnt = 0;
    logic [15:0] raddr = '0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) busy = 0;
      else if (imem_valid) busy = 0;
      else if (busy && imem_req) chk("req_addr_held", {16'd0, imem_addr}, {16'd0, raddr});
      else if (!busy && imem_req) begin
        busy  = 1;
        cnt   = 0;
        raddr = imem_addr;
      end
      @(posedge clk);
      #1;
      imem_valid = 1'b0;
      if (busy) begin
        cnt++;
        if (cnt >= mem_lat) begin
          imem_valid = 1'b1;
          imem_rdata = mem_read(raddr);
        end
      end
    end
  end

  // Program-order model: the next instruction to present is m_pc; every
  // fire advances it, every redirect replaces it.
  initial begin
    logic [15:0] m_pc = 16'h0000;
    bit          m_halted = 0;
    logic [15:0] m_instr;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_pc     = 16'h0000;
        m_halted = 0;
      end else begin
        m_instr = mem_read(m_pc);
        chk("m_halted", {31'd0, halted}, {31'd0, m_halted});
        if (m_halted) begin
          chk("m_halt_noreq", {31'd0, imem_req}, 32'd0);
          chk("m_halt_novalid", {31'd0, if_valid}, 32'd0);
        end
        if (if_valid) begin
          chk("m_if_pc", {16'd0, if_pc}, {16'd0, m_pc});
          chk("m_if_instr", {16'd0, if_instr}, {16'd0, m_instr});
          if (!if_ready || redirect)
            chk("m_noreq_hold", {31'd0, imem_req}, 32'd0);
          else if (m_instr[15:12] != 4'hF)
            chk("m_req_on_fire", {31'd0, imem_req}, 32'd1);
        end
        if (imem_req)
          chk("m_req_addr", {16'd0, imem_addr},
              {16'd0, (if_valid ? m_pc + 16'd1 : m_pc)});
        if (redirect) begin
          m_pc     = redirect_pc;
          m_halted = 0;
        end else if (if_valid && if_ready) begin
          fire_cnt++;
          if (m_instr[15:12] == 4'hF) m_halted = 1;
          m_pc = m_pc + 16'd1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned f0;
    logic [15:0] h_pc, h_instr;
    mem_img[16'h0000] = 16'h0123;
    mem_img[16'h0007] = 16'hF000;
    rst = 1'b1; if_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", {16'd0, if_instr}, 32'd0);
    chk("rst_pc", {16'd0, if_pc}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_addr", {16'd0, imem_addr}, 32'h0000);
    chk("rst_addr2", {16'd0, addr2}, 32'hFFFF);
    chk("rst_halted2", {31'd0, halted2}, 32'd0);

    // Basic fetch, 1-cycle memory.
    step(); rst = 1'b0;
    @(negedge clk); chk("idle_noreq", {31'd0, imem_req}, 32'd0);
    step();
    @(negedge clk);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", {16'd0, imem_addr}, 32'h0000);
    chk("first_addr2", {16'd0, addr2}, 32'hFFFF);
    step();
    @(negedge clk); chk("valid_lag", {31'd0, if_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("inst0_valid", {31'd0, if_valid}, 32'd1);
    chk("inst0_instr", {16'd0, if_instr}, 32'h0123);
    chk("inst0_pc", {16'd0, if_pc}, 32'h0000);
    chk("inst0_next_req", {31'd0, imem_req}, 32'd1);
    chk("inst0_next_addr", {16'd0, imem_addr}, 32'h0001);
    chk("wrap_pc2", {16'd0, pc2}, 32'hFFFF);
    chk("wrap_instr2", {16'd0, instr2}, 32'h0123);
    chk("wrap_valid2", {31'd0, valid2}, 32'd1);
    chk("wrap_req2", {31'd0, req2}, 32'd1);
    chk("wrap_addr2", {16'd0, addr2}, 32'h0000);
    step(); f0 = fire_cnt;
    repeat (8) step();
    chk("throughput", fire_cnt - f0, 32'd4);

    // Decode stall.
    if_ready = 1'b0;
    wait_valid("stall_wait");
    chk("stall_pc", {16'd0, if_pc}, 32'h0005);
    h_pc = if_pc; h_instr = if_instr;
    repeat (4) begin
      step();
      @(negedge clk);
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_instr", {16'd0, if_instr}, {16'd0, h_instr});
      chk("stall_hold_pc", {16'd0, if_pc}, {16'd0, h_pc});
      chk("stall_noreq", {31'd0, imem_req}, 32'd0);
    end
    step(); if_ready = 1'b1;
    @(negedge clk);
    chk("release_req", {31'd0, imem_req}, 32'd1);
    chk("release_addr", {16'd0, imem_addr}, 32'h0006);
    step();
    @(negedge clk);
    chk("single_fire", {31'd0, if_valid}, 32'd0);
    mem_lat = 3;

    // Redirect during an outstanding 3-cycle request.
    step(); if_ready = 1'b0;
    wait_valid("lat3_wait");
    chk("lat3_hold_pc", {16'd0, if_pc}, 32'h0006);
    step(); redirect = 1'b1; redirect_pc = 16'h0005;
    @(negedge clk); chk("redir_full_noreq", {31'd0, imem_req}, 32'd0);
    step(); redirect = 1'b0;
    @(negedge clk);
    chk("req5", {31'd0, imem_req}, 32'd1);
    chk("req5_addr", {16'd0, imem_addr}, 32'h0005);
    step(); redirect = 1'b1; redirect_pc = 16'h0040;
    step(); redirect = 1'b0;
    @(negedge clk); chk("drain_noreq", {31'd0, imem_req}, 32'd0);
    step();
    @(negedge clk);
    chk("drain_noreq2", {31'd0, imem_req}, 32'd0);
    chk("drain_novalid", {31'd0, if_valid}, 32'd0);
    step(); if_ready = 1'b1;
    @(negedge clk);
    chk("req40", {31'd0, imem_req}, 32'd1);
    chk("req40_addr", {16'd0, imem_addr}, 32'h0040);
    wait_valid("inst40_wait");
    chk("inst40_pc", {16'd0, if_pc}, 32'h0040);
    chk("inst40_instr", {16'd0, if_instr}, 32'h1040);
    mem_lat = 1;

    // Redirect coinciding with fire, then HALT.
    step(); if_ready = 1'b0;
    wait_valid("hold41_wait");
    chk("hold41_pc", {16'd0, if_pc}, 32'h0041);
    step(); if_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0007;
    @(negedge clk);
    chk("fire_redir_noreq", {31'd0, imem_req}, 32'd0);
    step(); redirect = 1'b0;
    @(negedge clk);
    chk("redir7_req", {31'd0, imem_req}, 32'd1);
    chk("redir7_addr", {16'd0, imem_addr}, 32'h0007);
    chk("no_represent", {31'd0, if_valid}, 32'd0);
    step();
    @(negedge clk); chk("halt_lag", {31'd0, if_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("halt_valid", {31'd0, if_valid}, 32'd1);
    chk("halt_instr", {16'd0, if_instr}, 32'hF000);
    chk("halt_pc", {16'd0, if_pc}, 32'h0007);
    chk("halt_not_yet", {31'd0, halted}, 32'd0);
    chk("halt_fire_noreq", {31'd0, imem_req}, 32'd0);
    repeat (4) begin
      step();
      @(negedge clk);
      chk("halted_set", {31'd0, halted}, 32'd1);
      chk("halted_noreq", {31'd0, imem_req}, 32'd0);
      chk("halted_novalid", {31'd0, if_valid}, 32'd0);
    end
    step(); redirect = 1'b1; redirect_pc = 16'h0000;
    step(); redirect = 1'b0;
    @(negedge clk);
    chk("resume_halted", {31'd0, halted}, 32'd0);
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    chk("resume_addr", {16'd0, imem_addr}, 32'h0000);
    wait_valid("resume_wait");
    chk("resume_pc", {16'd0, if_pc}, 32'h0000);
    chk("resume_instr", {16'd0, if_instr}, 32'h0123);
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
